// File: rtl/sfm_pkg.sv
// Shared types and constants for the softmax accelerator load/store arbiter.
package sfm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } sfm_arb_owner_e;

   localparam int SFM_PERF_CNT_W = 32;

endpackage : sfm_pkg

// File: rtl/sfm_arb_perf_cnt.sv
// Performance counters for the load/store arbiter: load handshakes, store
// handshakes and request-conflict cycles. All three wrap and are cleared by
// rst_i or clear_i. Instantiated only when SFM_ARB_PERF_CNT_EN is defined.
module sfm_arb_perf_cnt
   import sfm_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  logic                      ld_hs_i,
   input  logic                      st_hs_i,
   input  logic                      conflict_i,
   output logic [SFM_PERF_CNT_W-1:0] perf_ld_cnt_o,
   output logic [SFM_PERF_CNT_W-1:0] perf_st_cnt_o,
   output logic [SFM_PERF_CNT_W-1:0] perf_conflict_cnt_o
);

   logic [SFM_PERF_CNT_W-1:0] r_ld_cnt;
   logic [SFM_PERF_CNT_W-1:0] r_st_cnt;
   logic [SFM_PERF_CNT_W-1:0] r_conflict_cnt;

   // Count events; a clear in the same cycle as an event takes priority.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_ld_cnt       <= '0;
         r_st_cnt       <= '0;
         r_conflict_cnt <= '0;
      end else begin
         if (ld_hs_i)    r_ld_cnt       <= r_ld_cnt + 1'b1;
         if (st_hs_i)    r_st_cnt       <= r_st_cnt + 1'b1;
         if (conflict_i) r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
   end

   assign perf_ld_cnt_o       = r_ld_cnt;
   assign perf_st_cnt_o       = r_st_cnt;
   assign perf_conflict_cnt_o = r_conflict_cnt;

endmodule : sfm_arb_perf_cnt

// File: rtl/sfm_ldst_arbiter.sv
// Work-conserving, burst-bounded round-robin arbiter sharing one TCDM master
// port between the softmax load and store streamers, with read-response
// routing back to the issuing channel.
// Optional feature macro: SFM_ARB_PERF_CNT_EN (performance counters).
module sfm_ldst_arbiter
   import sfm_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  logic                      enable_i,
   input  logic                      ld_req_i,
   output logic                      ld_gnt_o,
   input  logic [ADDR_WIDTH-1:0]     ld_add_i,
   output logic                      ld_r_valid_o,
   output logic [DATA_WIDTH-1:0]     ld_r_data_o,
   input  logic                      st_req_i,
   output logic                      st_gnt_o,
   input  logic [ADDR_WIDTH-1:0]     st_add_i,
   input  logic [DATA_WIDTH-1:0]     st_data_i,
   input  logic [DATA_WIDTH/8-1:0]   st_be_i,
   output logic                      st_r_valid_o,
   output logic                      tcdm_req_o,
   input  logic                      tcdm_gnt_i,
   output logic [ADDR_WIDTH-1:0]     tcdm_add_o,
   output logic                      tcdm_wen_o,
   output logic [DATA_WIDTH-1:0]     tcdm_data_o,
   output logic [DATA_WIDTH/8-1:0]   tcdm_be_o,
   input  logic                      tcdm_r_valid_i,
   input  logic [DATA_WIDTH-1:0]     tcdm_r_data_i,
   output logic [SFM_PERF_CNT_W-1:0] perf_ld_cnt_o,
   output logic [SFM_PERF_CNT_W-1:0] perf_st_cnt_o,
   output logic [SFM_PERF_CNT_W-1:0] perf_conflict_cnt_o
);

   localparam int BCNT_W = $clog2(MAX_BURST + 1);
   localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(MAX_BURST);

   sfm_arb_owner_e    r_owner;
   logic [BCNT_W-1:0] r_bcnt;
   logic              r_resp_vld;
   sfm_arb_owner_e    r_resp_own;
   logic              r_flush;

   sfm_arb_owner_e    w_sel;
   logic              w_sel_ld;
   logic              w_sel_st;
   logic              w_en;
   logic              w_hs;

   // Pick the channel for this cycle: the owner keeps the port until its burst
   // budget runs out while the other side waits; an idle port goes to whoever
   // asks, with load preferred on a tie.
   always_comb begin
      w_sel = IDLE;
      case (r_owner)
         LOAD: begin
            if (ld_req_i && ((r_bcnt < BMAX) || !st_req_i)) w_sel = LOAD;
            else if (st_req_i)                              w_sel = STORE;
         end
         STORE: begin
            if (st_req_i && ((r_bcnt < BMAX) || !ld_req_i)) w_sel = STORE;
            else if (ld_req_i)                              w_sel = LOAD;
         end
         default: begin
            if (ld_req_i)      w_sel = LOAD;
            else if (st_req_i) w_sel = STORE;
         end
      endcase
   end

   // Reset also masks the request path so nothing leaks out while rst_i is high.
   assign w_en     = enable_i & ~rst_i;
   assign w_sel_ld = (w_sel == LOAD);
   assign w_sel_st = (w_sel == STORE);

   assign tcdm_req_o  = w_en & (w_sel_ld | w_sel_st);
   assign tcdm_add_o  = w_sel_st ? st_add_i : ld_add_i;
   assign tcdm_wen_o  = ~w_sel_st;
   assign tcdm_data_o = w_sel_st ? st_data_i : '0;
   assign tcdm_be_o   = w_sel_st ? st_be_i : '1;

   assign ld_gnt_o = w_sel_ld & tcdm_gnt_i & w_en;
   assign st_gnt_o = w_sel_st & tcdm_gnt_i & w_en;
   assign w_hs     = tcdm_req_o & tcdm_gnt_i;

   // Owner, burst count and in-flight response tracking advance only on a
   // handshake; clear beats a simultaneous handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_owner    <= IDLE;
         r_bcnt     <= '0;
         r_resp_vld <= 1'b0;
         r_resp_own <= IDLE;
      end else begin
         r_resp_vld <= w_hs;
         if (w_hs) begin
            r_owner    <= w_sel;
            r_resp_own <= w_sel;
            if (w_sel != r_owner)  r_bcnt <= BCNT_W'(1);
            else if (r_bcnt != BMAX) r_bcnt <= r_bcnt + 1'b1;
         end
      end
   end

   // Remember a flush so a response to a transaction cancelled by it is
   // dropped quietly instead of being reported as stray.
   always_ff @(posedge clk_i) begin
      r_flush <= rst_i | clear_i;
   end

   assign ld_r_valid_o = tcdm_r_valid_i & r_resp_vld & ~rst_i & (r_resp_own == LOAD);
   assign st_r_valid_o = tcdm_r_valid_i & r_resp_vld & ~rst_i & (r_resp_own == STORE);
   assign ld_r_data_o  = tcdm_r_data_i;

   // A response with no outstanding request is a protocol violation upstream.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(tcdm_r_valid_i && !r_resp_vld && !r_flush))
            else $error("sfm_ldst_arbiter: stray tcdm_r_valid_i dropped");
      end
   end

`ifdef SFM_ARB_PERF_CNT_EN
   sfm_arb_perf_cnt u_perf_cnt (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .clear_i             (clear_i),
      .ld_hs_i             (w_hs & w_sel_ld),
      .st_hs_i             (w_hs & w_sel_st),
      .conflict_i          (ld_req_i & st_req_i & enable_i),
      .perf_ld_cnt_o       (perf_ld_cnt_o),
      .perf_st_cnt_o       (perf_st_cnt_o),
      .perf_conflict_cnt_o (perf_conflict_cnt_o)
   );
`else
   assign perf_ld_cnt_o       = '0;
   assign perf_st_cnt_o       = '0;
   assign perf_conflict_cnt_o = '0;
`endif

endmodule : sfm_ldst_arbiter

// File: doc/sfm_ldst_arbiter.md
# sfm_ldst_arbiter

Shares the softmax accelerator's single TCDM master port between the load path and the store path. It replaces the static two-way mux and free-running priority bit with a work-conserving, burst-bounded round-robin arbiter. It also routes read responses back to the requester that issued them. It sits between the two streamer FIFOs and the TCDM master interface.

## Interface
- DATA_WIDTH, 256, TCDM data width in bits; BE width is DATA_WIDTH/8
- ADDR_WIDTH, 32, TCDM address width
- MAX_BURST, 4, max consecutive grants to one channel while the other waits; must be ≥1
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous soft clear, same effect as rst_i on state
- enable_i  in  1  when low, no new grants are issued
- ld_req_i / ld_gnt_o  in/out  1  load channel request/grant
- ld_add_i  in  ADDR_WIDTH  load address
- ld_r_valid_o  out  1  load response valid
- ld_r_data_o  out  DATA_WIDTH  load response data
- st_req_i / st_gnt_o  in/out  1  store channel request/grant
- st_add_i  in  ADDR_WIDTH  store address
- st_data_i  in  DATA_WIDTH  store data
- st_be_i  in  DATA_WIDTH/8  store byte enables
- st_r_valid_o  out  1  store write acknowledge
- tcdm_req_o / tcdm_gnt_i  out/in  1  master request/grant
- tcdm_add_o  out  ADDR_WIDTH  master address
- tcdm_wen_o  out  1  1 = read (load), 0 = write (store)
- tcdm_data_o  out  DATA_WIDTH  master write data
- tcdm_be_o  out  DATA_WIDTH/8  master byte enables; all-ones for loads
- tcdm_r_valid_i  in  1  master response valid
- tcdm_r_data_i  in  DATA_WIDTH  master response data
- perf_ld_cnt_o, perf_st_cnt_o, perf_conflict_cnt_o  out  32 each  performance counters (see Configuration)

## Operation
- FSM owner states: IDLE, LOAD, STORE. Burst counter `bcnt` has width $clog2(MAX_BURST+1).
- Selection is combinational from the owner state and the requests:
  - owner LOAD: keep LOAD if ld_req_i and (bcnt<MAX_BURST or !st_req_i); otherwise STORE if st_req_i.
  - owner STORE: symmetric.
  - IDLE, or owner not requesting: the other requester wins. If both request from IDLE, LOAD wins.
- Only the selected channel's req/add/data/be drive tcdm_*. tcdm_req_o = enable_i & sel_req. The selected channel's gnt is tcdm_gnt_i & enable_i. The other gnt is 0.
- On a handshake (tcdm_req_o & tcdm_gnt_i):
  - owner ← selected channel.
  - bcnt ← 1 on an owner change, else bcnt+1, saturating at MAX_BURST.
- No handshake for a cycle: owner and bcnt hold. The arbiter never returns to IDLE except on reset or clear.
- Response routing:
  - Each handshake sets resp_vld ← 1 and resp_own ← selected channel. A cycle with no handshake clears resp_vld.
  - tcdm_r_valid_i is forwarded to ld_r_valid_o or st_r_valid_o per resp_own. tcdm_r_data_i goes to ld_r_data_o unconditionally.
  - tcdm_r_valid_i while resp_vld=0 is dropped and flagged by a simulation assertion.
- Boundary conditions:
  - rst_i or clear_i mid-burst: FSM → IDLE, bcnt → 0, resp_vld → 0. A response arriving the next cycle is dropped.
  - enable_i low: both gnts 0, tcdm_req_o 0, state holds.
  - Simultaneous handshake and clear: clear wins.

## Timing
- Request to TCDM is zero-latency: combinational, same cycle.
- Response latency from the TCDM is fixed at 1 cycle after grant; the arbiter adds no latency on the response path.
- Values while rst_i is high and after reset:
  - owner IDLE, bcnt 0, resp_vld 0.
  - tcdm_req_o, ld_gnt_o, st_gnt_o, ld_r_valid_o, st_r_valid_o all 0.
  - perf counters 0.
- Requesters must hold req/add/data stable until granted; the arbiter does not latch them.
- Worst-case wait for the non-owner is MAX_BURST cycles with continuous grants.

## Configuration
- SFM_ARB_PERF_CNT_EN defined: three 32-bit wrapping counters, cleared by rst_i and clear_i:
  - perf_ld_cnt_o: load handshakes.
  - perf_st_cnt_o: store handshakes.
  - perf_conflict_cnt_o: cycles with ld_req_i & st_req_i & enable_i.
- SFM_ARB_PERF_CNT_EN undefined: the perf ports exist but are tied to 0 and no counter flops are generated.

## Structure
- Shared package sfm_pkg holds:
  - enum sfm_arb_owner_e {IDLE, LOAD, STORE}
  - localparam SFM_PERF_CNT_W = 32
- One sub-module, sfm_arb_perf_cnt, holds the three counters and is instantiated only under the macro.

## Test plan
- Only ld_req_i high for 6 cycles, tcdm_gnt_i=1 → 6 consecutive load grants, tcdm_wen_o=1; ld_r_valid_o follows each grant by 1 cycle with the returned data.
- Both requests high continuously, MAX_BURST=4, gnt=1 → grant pattern L,L,L,L,S,S,S,S,L…
- Load owner with bcnt=2 and ld_req_i drops while st_req_i is high → store granted the same cycle; bcnt=1 after the handshake.
- tcdm_gnt_i=0 for 3 cycles during a store burst → store gnt low, bcnt and owner unchanged; resumes on the 4th cycle.
- clear_i asserted in the same cycle as a load handshake → state IDLE, no ld_r_valid_o the next cycle; then both requesting → LOAD wins.
- With SFM_ARB_PERF_CNT_EN, 10 cycles of both requesting at MAX_BURST=4 → perf_ld_cnt_o=6, perf_st_cnt_o=4, perf_conflict_cnt_o=10.
